// File: rtl/ysyx_22051468_reg_scoreboard.sv
// Decode-to-issue GPR hazard scoreboard: per-register pending-write counters, issue stall, sticky underflow flag.
// Optional same-cycle writeback bypass of the busy/full checks: define YSYX_22051468_SB_WB_BYPASS_EN.
module ysyx_22051468_reg_scoreboard #(
  parameter int NR_REG = 32,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic              rd_need,
  input  logic              rs1_need,
  input  logic              rs2_need,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic              flush,
  output logic [NR_REG-1:0] busy_vec,
  output logic              sb_err,
  output logic [PERF_W-1:0] stall_cnt
);

  // Handshake: an instruction issues on a cycle where id_valid && id_ready.
  // id_ready is a function of scoreboard state, source/dest indices, wb and flush only.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q [NR_REG];
  logic [CNT_W-1:0]  cnt_d [NR_REG];
  logic [CNT_W-1:0]  rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
  logic              wb_hit, fire, fire_wr;
  logic              rs1_busy, rs2_busy, rd_full;
  logic [NR_REG-1:0] inc_vec, dec_vec;
  logic              err_set;

  assign rs1_cnt = cnt_q[rs1];
  assign rs2_cnt = cnt_q[rs2];
  assign rd_cnt  = cnt_q[rd];
  assign wb_cnt  = cnt_q[wb_rd];
  assign wb_hit  = wb_valid && (wb_rd != 5'd0);

`ifdef YSYX_22051468_SB_WB_BYPASS_EN
  // The last pending producer writing back this cycle releases its register immediately.
  assign rs1_busy = (rs1_cnt != '0) && !(wb_hit && (wb_rd == rs1) && (rs1_cnt == CNT_ONE));
  assign rs2_busy = (rs2_cnt != '0) && !(wb_hit && (wb_rd == rs2) && (rs2_cnt == CNT_ONE));
  assign rd_full  = (rd_cnt == CNT_MAX) && !(wb_hit && (wb_rd == rd));
`else
  assign rs1_busy = (rs1_cnt != '0);
  assign rs2_busy = (rs2_cnt != '0);
  assign rd_full  = (rd_cnt == CNT_MAX);
`endif

  assign id_ready = !flush
                 && !(rs1_need && (rs1 != 5'd0) && rs1_busy)
                 && !(rs2_need && (rs2 != 5'd0) && rs2_busy)
                 && !(rd_need  && (rd  != 5'd0) && rd_full);

  assign fire    = id_valid && id_ready;
  assign fire_wr = fire && rd_need && (rd != 5'd0);
  assign inc_vec = fire_wr ? (NR_REG'(1) << rd) : '0;
  assign dec_vec = wb_hit  ? (NR_REG'(1) << wb_rd) : '0;

  // A writeback against an empty counter is an error unless a same-register issue cancels it out.
  assign err_set = wb_hit && !flush && (wb_cnt == '0) && !(fire_wr && (rd == wb_rd));

  always_comb begin
    for (int i = 0; i < NR_REG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if (i != 0) begin
        case ({inc_vec[i], dec_vec[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
          2'b01:   if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_ONE;
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR_REG; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NR_REG; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NR_REG; i++) busy_vec[i] = (cnt_q[i] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (err_set) sb_err <= 1'b1;
      if (id_valid && !id_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/ysyx_22051468_reg_scoreboard.md
Name: ysyx_22051468_reg_scoreboard

Overview:
- Decode-to-issue hazard scoreboard. It sits directly downstream of the decoder's rd/rs1/rs2/imm "need" flags.
- Tracks outstanding GPR writes with a small counter per register. Stalls issue of any instruction whose needed source, or whose destination counter, would create a hazard.
- Writeback-stage completions retire pending writes.
- Provides a sticky underflow error flag and a stall-cycle performance counter.

Parameters:
NR_REG, 32, number of architectural GPRs tracked (x0 never tracked)
CNT_W, 2, width of per-register pending-write counter; max in-flight writes per register = 2^CNT_W-1
PERF_W, 32, width of stall-cycle counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  decoded instruction presented for issue
id_ready  output  1  scoreboard accepts instruction this cycle
rd_need  input  1  instruction writes rd (from decoder)
rs1_need  input  1  instruction reads rs1
rs2_need  input  1  instruction reads rs2
rd  input  5  destination register index
rs1  input  5  source 1 index
rs2  input  5  source 2 index
wb_valid  input  1  one register write completes this cycle
wb_rd  input  5  register index being written back
flush  input  1  pipeline flush; clears all pending state
busy_vec  output  NR_REG  bit i = register i has pending count != 0 (bit 0 always 0)
sb_err  output  1  sticky: writeback to register with zero pending count
stall_cnt  output  PERF_W  cycles with id_valid=1 and id_ready=0

Behaviour:
- Reset (async, rst_n=0): all counters 0, busy_vec=0, sb_err=0, stall_cnt=0.
- id_ready is combinational and deasserts if any of the following holds:
  - rs1_need && rs1!=0 && busy(rs1)
  - rs2_need && rs2!=0 && busy(rs2)
  - rd_need && rd!=0 && cnt[rd]==max
  - flush=1
- busy(r) = cnt[r]!=0 (see optional feature for same-cycle writeback).
- id_ready does not depend on id_valid (no combinational loop).
- Issue fire = id_valid && id_ready.
- On fire with rd_need && rd!=0, cnt[rd] increments at the next edge.
- rd_need=0 or rd=0: no counter change.
- Writeback (wb_valid && wb_rd!=0):
  - cnt[wb_rd]>0: decrements at the next edge.
  - cnt[wb_rd]==0: counter stays 0 and sb_err sets (sticky until reset).
  - wb_rd=0 is ignored.
- Fire and writeback to the same register in the same cycle: counter unchanged (net 0). No overflow or underflow check is applied in that case.
- Fire and writeback to different registers: both updates are applied.
- flush=1: all counters clear to 0 at the next edge; a concurrent writeback is ignored (no sb_err). Upstream guarantees flushed instructions never write back.
- busy_vec is registered-state derived (reflects counters, not the current-cycle writeback).
- stall_cnt increments each cycle with id_valid && !id_ready and saturates at all-ones.
- Latency: a writeback makes its register available for issue in the next cycle (1-cycle bubble) unless the optional feature is enabled.

Optional Feature:
- Macro: YSYX_22051468_SB_WB_BYPASS_EN.
- Defined: busy(r) = cnt[r]!=0 && !(wb_valid && wb_rd==r && cnt[r]==1). A dependent instruction issues in the same cycle its last pending producer writes back. The rd-full check likewise treats cnt[rd]==max with a same-cycle writeback to rd as not full.
- Undefined: busy(r) = cnt[r]!=0 only; one extra stall cycle after the final writeback.

Test Plan:
- Reset then issue rd=5, rd_need=1 -> busy_vec[5]=1 next cycle; issue rs1=5, rs1_need=1 -> id_ready=0, stall_cnt counts 1 per cycle.
- wb_valid, wb_rd=5 with dependent waiting -> bypass off: id_ready=1 one cycle after wb; bypass on: id_ready=1 in the wb cycle; busy_vec[5]=0 after the edge.
- Three issues to rd=7 (CNT_W=2) -> cnt=3, fourth issue to rd=7 stalls; one wb to 7 -> fourth issues, cnt back to 3.
- Same-cycle issue rd=9 and wb_rd=9 with cnt[9]=1 -> cnt[9] stays 1, busy_vec[9]=1, sb_err=0.
- wb_rd=12 with cnt[12]=0 -> sb_err=1 and stays 1; writes with rd=0/wb_rd=0 -> no state change, busy_vec[0]=0.
- Regs 3, 4 pending, assert flush with wb_rd=3 -> id_ready=0 that cycle, busy_vec=0 next cycle, sb_err unchanged; assert rst_n=0 mid-stall -> stall_cnt and all state clear immediately.
